inst_loader: RTL and testbench

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader_if.sv | 25 ++
 rtl/inst_loader.sv | 123 ++++++++++++
 tb/tb_inst_loader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/inst_loader_if.sv
// Byte-stream / core-fetch bundle for the UART instruction loader.
// master = UART receiver + core side, slave = loader.
`ifndef WIDTH
`define WIDTH 32
`endif

interface inst_loader_if;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [`WIDTH-1:0] program_counter;
    logic [`WIDTH-1:0] instr;
    logic              core_rstn;
    logic              loaded;
    logic              load_err;

    modport master (
        output rx_data, rx_valid, program_counter,
        input  instr, core_rstn, loaded, load_err
    );

    modport slave (
        input  rx_data, rx_valid, program_counter,
        output instr, core_rstn, loaded, load_err
    );
endinterface

// File: rtl/inst_loader.sv
// Loads a big-endian word stream from a UART into instruction memory, then releases the core.
// Define LOADER_CHECKSUM_EN to add the trailing XOR checksum byte (CHK/ERR states).
`ifndef WIDTH
`define WIDTH 32
`endif

module inst_loader #(
    parameter int ADDR_W = 10
) (
    input  logic         clk,
    input  logic         rst,
    inst_loader_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_LEN, S_LOAD, S_RUN, S_CHK, S_ERR} state_t;
    localparam state_t S_DONE = S_CHK;
`else
    typedef enum logic [2:0] {S_LEN, S_LOAD, S_RUN} state_t;
    localparam state_t S_DONE = S_RUN;
`endif

    state_t      r_state, w_next;
    logic [1:0]  r_bcnt;
    logic [23:0] r_shift;
    logic [31:0] r_n;
    logic [31:0] r_widx;
    logic        r_wen;
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0] r_wdata;
    logic        r_core_rstn;
    logic        r_loaded;
    logic [31:0] r_mem [DEPTH];

    logic [31:0] w_word;
    logic        w_accept;
    logic        w_last_byte;
    logic        w_unused_pc;

    assign w_word      = {r_shift, bus.rx_data};
    assign w_last_byte = w_accept && (r_bcnt == 2'd3);

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_csum;
    logic       r_load_err;
    assign w_accept = bus.rx_valid &&
                      (r_state == S_LEN || r_state == S_LOAD || r_state == S_CHK);
`else
    assign w_accept = bus.rx_valid && (r_state == S_LEN || r_state == S_LOAD);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_LEN;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LEN:  if (w_last_byte) w_next = (w_word != 32'd0) ? S_LOAD : S_DONE;
            S_LOAD: if (w_last_byte && (r_widx + 32'd1 == r_n)) w_next = S_DONE;
`ifdef LOADER_CHECKSUM_EN
            S_CHK:  if (w_accept) w_next = (bus.rx_data == r_csum) ? S_RUN : S_ERR;
`endif
            default: w_next = r_state;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcnt      <= 2'd0;
            r_shift     <= 24'd0;
            r_n         <= 32'd0;
            r_widx      <= 32'd0;
            r_wen       <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= 32'd0;
            r_core_rstn <= 1'b0;
            r_loaded    <= 1'b0;
        end else begin
            r_wen       <= 1'b0;
            r_core_rstn <= (w_next == S_RUN);
            r_loaded    <= (w_next == S_RUN) && (r_state != S_RUN);
            if (w_next != r_state)  r_bcnt <= 2'd0;
            else if (w_accept)      r_bcnt <= r_bcnt + 2'd1;
            if (w_accept) r_shift <= {r_shift[15:0], bus.rx_data};
            if (w_last_byte && r_state == S_LEN) r_n <= w_word;
            // Words past the end of memory are consumed; widx keeps counting to N.
            if (w_last_byte && r_state == S_LOAD) begin
                r_wen   <= (r_widx[31:ADDR_W] == '0);
                r_waddr <= r_widx[ADDR_W-1:0];
                r_wdata <= w_word;
                r_widx  <= r_widx + 32'd1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csum     <= 8'd0;
            r_load_err <= 1'b0;
        end else begin
            if (w_accept && r_state != S_CHK) r_csum <= r_csum ^ bus.rx_data;
            r_load_err <= (w_next == S_ERR);
        end
    end
    assign bus.load_err = r_load_err;
`else
    assign bus.load_err = 1'b0;
`endif

    // Memory is deliberately outside the reset domain so contents survive rst.
    always_ff @(posedge clk) begin
        if (r_wen) r_mem[r_waddr] <= r_wdata;
    end

    assign bus.instr     = (r_state == S_RUN) ? r_mem[bus.program_counter[ADDR_W+1:2]] : '0;
    assign bus.core_rstn = r_core_rstn;
    assign bus.loaded    = r_loaded;
    assign w_unused_pc   = ^{bus.program_counter[`WIDTH-1:ADDR_W+2], bus.program_counter[1:0]};
endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: stimulus queues expectations, a negedge monitor checks them.
`ifndef WIDTH
`define WIDTH 32
`endif

module tb_inst_loader;
    localparam int ADDR_W = 1;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        rstn;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    inst_loader_if bus();

    inst_loader #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    exp_t        sq[$];
    string       lq[$];
    logic        smp = 1'b0;
    logic [7:0]  csum = 8'd0;
    exp_t        m_e;
    string       m_n;

    // Monitor: compares queued expectations and accounts for every loaded pulse.
    always @(negedge clk) begin
        if (smp) begin
            checks++;
            if (sq.size() == 0) begin
                failures++;
                $display("FAIL sample: no expectation queued");
            end else begin
                m_e = sq.pop_front();
                if (bus.instr !== m_e.instr || bus.core_rstn !== m_e.rstn || bus.load_err !== m_e.err) begin
                    failures++;
                    $display("FAIL %s: instr=%h core_rstn=%b load_err=%b, expected instr=%h core_rstn=%b load_err=%b",
                             m_e.name, bus.instr, bus.core_rstn, bus.load_err, m_e.instr, m_e.rstn, m_e.err);
                end
            end
        end
        if (bus.loaded === 1'b1) begin
            checks++;
            if (lq.size() == 0) begin
                failures++;
                $display("FAIL loaded: unexpected pulse, got 1 expected 0");
            end else begin
                m_n = lq.pop_front();
                if (bus.core_rstn !== 1'b1) begin
                    failures++;
                    $display("FAIL %s loaded: core_rstn=%b expected 1", m_n, bus.core_rstn);
                end
            end
        end
    end

    // All tasks start and end at 1 time unit after a rising edge.
    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        csum         = csum ^ b;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        send(w[31:24]); send(w[23:16]); send(w[15:8]); send(w[7:0]);
    endtask

    task automatic send_csum();
`ifdef LOADER_CHECKSUM_EN
        send(csum);
`endif
    endtask

    task automatic expect_out(input string n, input logic [31:0] pc, input logic [31:0] ins,
                              input logic rstn, input logic err);
        exp_t e;
        e.name = n; e.instr = ins; e.rstn = rstn; e.err = err;
        bus.program_counter = pc;
        sq.push_back(e);
        smp = 1'b1;
        @(posedge clk); #1;
        smp = 1'b0;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        csum = 8'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Last byte of a stream that should reach RUN: queue the loaded pulse first.
    task automatic finish_good(input string n, input logic [31:0] last_word, input logic has_word);
        lq.push_back(n);
`ifdef LOADER_CHECKSUM_EN
        if (has_word) send_word(last_word);
        send(csum);
`else
        if (has_word) begin
            send(last_word[31:24]); send(last_word[23:16]); send(last_word[15:8]);
            send(last_word[7:0]);
        end
`endif
    endtask

    initial begin
        bus.rx_data = 8'd0;
        bus.rx_valid = 1'b0;
        bus.program_counter = '0;
        #2;
        do_rst();
        expect_out("reset_state", 32'd0, 32'd0, 1'b0, 1'b0);

        // Two-word program
        send_word(32'd2);
        send_word(32'h20010005);
        finish_good("load2", 32'h00221820, 1'b1);
        expect_out("load2_first_run_pc0", 32'd0, 32'h20010005, 1'b1, 1'b0);
        expect_out("load2_pc4", 32'd4, 32'h00221820, 1'b1, 1'b0);
        expect_out("load2_pc7_lowbits", 32'd7, 32'h00221820, 1'b1, 1'b0);
        expect_out("load2_pc_highbits", 32'hFFFF_FFF0, 32'h20010005, 1'b1, 1'b0);

        // Zero-length program keeps previous memory
        do_rst();
        expect_out("preload_instr_zero", 32'd4, 32'd0, 1'b0, 1'b0);
        send(8'h00); send(8'h00); send(8'h00);
`ifdef LOADER_CHECKSUM_EN
        send(8'h00);
`endif
        finish_good("len0", 32'd0, 1'b0);
`ifndef LOADER_CHECKSUM_EN
        send(8'h00);
`endif
        expect_out("len0_first_run_pc0", 32'd0, 32'h20010005, 1'b1, 1'b0);
        expect_out("len0_pc4", 32'd4, 32'h00221820, 1'b1, 1'b0);

        // Reset mid-LOAD abandons the transfer
        do_rst();
        send_word(32'd1);
        send(8'hAB); send(8'hCD);
        do_rst();
        expect_out("midload_rst_state", 32'd0, 32'd0, 1'b0, 1'b0);
        send_word(32'd1);
        finish_good("reload1", 32'h0BADF00D, 1'b1);
        expect_out("reload1_mem1_kept", 32'd4, 32'h00221820, 1'b1, 1'b0);
        expect_out("reload1_mem0", 32'd0, 32'h0BADF00D, 1'b1, 1'b0);

        // Overflow: third word is dropped with ADDR_W=1
        do_rst();
        send_word(32'd3);
        send_word(32'h11111111);
        send_word(32'h22222222);
        finish_good("overflow", 32'h33333333, 1'b1);
        expect_out("overflow_pc4", 32'd4, 32'h22222222, 1'b1, 1'b0);
        expect_out("overflow_pc8_wraps", 32'd8, 32'h11111111, 1'b1, 1'b0);
        expect_out("overflow_pc0", 32'd0, 32'h11111111, 1'b1, 1'b0);

        // Traffic in RUN is ignored
        for (int i = 0; i < 8; i++) send(8'($urandom_range(0, 255)));
        expect_out("run_traffic_pc0", 32'd0, 32'h11111111, 1'b1, 1'b0);
        expect_out("run_traffic_pc4", 32'd4, 32'h22222222, 1'b1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: bytes XOR to 3C, send 00
        do_rst();
        send_word(32'd2);
        send_word(32'h20010005);
        send_word(32'h00221820);
        send(8'h00);
        expect_out("bad_csum_err", 32'd0, 32'd0, 1'b0, 1'b1);
        send(8'h3C); send(8'h55);
        expect_out("err_terminal", 32'd4, 32'd0, 1'b0, 1'b1);
        do_rst();
        expect_out("err_cleared_by_rst", 32'd0, 32'd0, 1'b0, 1'b0);
`endif

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (lq.size() != 0) begin
            failures++;
            $display("FAIL loaded_missing: %0d pulses not seen, expected 0", lq.size());
        end
        checks++;
        if (sq.size() != 0) begin
            failures++;
            $display("FAIL samples_pending: %0d left, expected 0", sq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
